dual_port_ram_be: RTL and testbench

- Parametrised simple dual-port synchronous RAM: one write port and one read port, independent addresses, both on one clock.
- Successor to the 8x16 single-address RAM. Adds:
  - configurable width and depth
  - per-byte write enables
  - selectable read-during-write behaviour
  - 1- or 2-cycle read latency, with a read-valid strobe
  - a self-clearing init sequencer after reset
- Sits behind FIFOs and packet buffers as their storage.

---
 rtl/dual_port_ram_be_pkg.sv | 39 +++
 rtl/dual_port_ram_be_if.sv | 31 +++
 rtl/dual_port_ram_be_rd_pipe.sv | 63 ++++++
 rtl/dual_port_ram_be.sv | 144 ++++++++++++++
 tb/tb_dual_port_ram_be.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dual_port_ram_be_pkg.sv
// -----------------------------------------------------------------------------
// dual_port_ram_pkg
// Shared types and helpers for the byte-enabled simple dual-port RAM.
//   ram_state_t : init sequencer states (CLEAR while wiping, RUN afterwards)
//   RDW_OLD/NEW : same-address read-during-write selection codes
//   byte_merge  : overlay enabled bytes of a new word onto an old word
// -----------------------------------------------------------------------------
package dual_port_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ram_state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word the merge helper handles; callers zero-extend into it and
    // truncate the result back to their own width.
    localparam int MAX_DATA_W = 512;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    // Byte k of the result is new_word's byte k when be[k] is set, else
    // old_word's byte k. Used by both the write path and the read bypass so
    // the two can never disagree.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int k = 0; k < MAX_BE_W; k++) begin
            merged[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dual_port_ram_be_if.sv
// -----------------------------------------------------------------------------
// dual_port_ram_be_if
// Write/read port bundle of the byte-enabled dual-port RAM.
//   master : client side (drives requests, receives dout/rd_valid/init_busy)
//   slave  : RAM side
// -----------------------------------------------------------------------------
interface dual_port_ram_be_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) ();
    logic                wr_enb;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W/8-1:0] wr_be;
    logic [DATA_W-1:0]   din;
    logic                rd_enb;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   dout;
    logic                rd_valid;
    logic                init_busy;

    modport master (
        output wr_enb, wr_addr, wr_be, din, rd_enb, rd_addr,
        input  dout, rd_valid, init_busy
    );

    modport slave (
        input  wr_enb, wr_addr, wr_be, din, rd_enb, rd_addr,
        output dout, rd_valid, init_busy
    );
endinterface

// File: rtl/dual_port_ram_be_rd_pipe.sv
// -----------------------------------------------------------------------------
// ram_rd_pipe
// Read-data output pipeline: 1 or 2 register stages, valid travels with data.
//   clock, rst       : clock, synchronous active-high reset (clears all stages)
//   i_valid, i_data  : read word accepted this cycle
//   o_valid, o_data  : registered result; o_data holds when no new result
// -----------------------------------------------------------------------------
module ram_rd_pipe #(
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);
    logic              w_valid;
    logic [DATA_W-1:0] w_data;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    generate
        if (READ_LATENCY == 2) begin : g_stage
            logic              r_stg_valid;
            logic [DATA_W-1:0] r_stg_data;

            // Extra capture stage for the 2-cycle latency option.
            always_ff @(posedge clock) begin
                if (rst) begin
                    r_stg_valid <= 1'b0;
                    r_stg_data  <= '0;
                end else begin
                    r_stg_valid <= i_valid;
                    r_stg_data  <= i_data;
                end
            end

            assign w_valid = r_stg_valid;
            assign w_data  = r_stg_data;
        end else begin : g_direct
            assign w_valid = i_valid;
            assign w_data  = i_data;
        end
    endgenerate

    // Output stage: dout only moves when a new result arrives.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_valid;
            if (w_valid) begin
                r_data <= w_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/dual_port_ram_be.sv
// -----------------------------------------------------------------------------
// dual_port_ram_be
// Simple dual-port synchronous RAM with byte enables, selectable
// read-during-write behaviour, 1/2-cycle read latency and a post-reset clear.
//   clock : single clock, rising edge
//   rst   : synchronous active-high reset; restarts the clear sequence
//   bus   : slave side of dual_port_ram_be_if (write port, read port,
//           dout/rd_valid/init_busy)
// -----------------------------------------------------------------------------
module dual_port_ram_be
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                  clock,
    input  logic                  rst,
    dual_port_ram_be_if.slave     bus
);
    localparam bit L_BYPASS = (RDW_MODE == RDW_NEW) && (RDW_MODE != RDW_OLD);

    ram_state_t        r_state;
    ram_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_clr_ptr_nxt;
    logic              r_init_busy;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic [DATA_W-1:0] w_wr_merge;

    logic              w_rd_acc;
    logic              w_rd_hit;
    logic [DATA_W-1:0] w_rd_old;
    logic [DATA_W-1:0] w_rd_new;
    logic [DATA_W-1:0] w_rd_word;

    logic              w_pipe_valid;
    logic [DATA_W-1:0] w_pipe_data;

    // Init sequencer next-state: walk clr_ptr across the array, then run.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            CLEAR: begin
                w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
                if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = CLEAR;
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt   = CLEAR;
                w_clr_ptr_nxt = '0;
            end
        endcase
    end

    // Init sequencer state register; reset always restarts the clear at 0.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state     <= CLEAR;
            r_clr_ptr   <= '0;
            r_init_busy <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_ptr   <= w_clr_ptr_nxt;
            r_init_busy <= (w_state_nxt == CLEAR);
        end
    end

    assign w_wr_merge = DATA_W'(byte_merge(MAX_DATA_W'(r_mem[bus.wr_addr]),
                                           MAX_DATA_W'(bus.din),
                                           MAX_BE_W'(bus.wr_be)));

    // Single memory write port shared by the clear sequencer and the client.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = bus.wr_addr;
        w_mem_data = w_wr_merge;
        if (rst) begin
            w_mem_we = 1'b0;
        end else if (r_state == CLEAR) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_clr_ptr;
            w_mem_data = '0;
        end else if (bus.wr_enb && (|bus.wr_be)) begin
            w_mem_we = 1'b1;
        end else begin
            w_mem_we = 1'b0;
        end
    end

    // Storage array; intentionally not reset, the sequencer wipes it.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    assign w_rd_acc = (r_state == RUN) && bus.rd_enb;
    assign w_rd_hit = bus.wr_enb && (bus.wr_addr == bus.rd_addr);
    assign w_rd_old = r_mem[bus.rd_addr];
    assign w_rd_new = DATA_W'(byte_merge(MAX_DATA_W'(w_rd_old),
                                         MAX_DATA_W'(bus.din),
                                         MAX_BE_W'(bus.wr_be)));

    // Read word selection: bypass only on a same-address collision.
    always_comb begin
        w_rd_word = w_rd_old;
        if (L_BYPASS && w_rd_hit) begin
            w_rd_word = w_rd_new;
        end else begin
            w_rd_word = w_rd_old;
        end
    end

    ram_rd_pipe #(
        .DATA_W      (DATA_W),
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_pipe (
        .clock  (clock),
        .rst    (rst),
        .i_valid(w_rd_acc),
        .i_data (w_rd_word),
        .o_valid(w_pipe_valid),
        .o_data (w_pipe_data)
    );

    assign bus.dout      = w_pipe_data;
    assign bus.rd_valid  = w_pipe_valid;
    assign bus.init_busy = r_init_busy;
endmodule

// File: tb/tb_dual_port_ram_be.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram_be
// Four RAM instances (latency 1/2 x old/new read-during-write) share one
// stimulus stream; a word-level reference model predicts every output.
// -----------------------------------------------------------------------------
module tb_dual_port_ram_be;
    localparam int DW   = 16;
    localparam int DP   = 16;
    localparam int NDUT = 4;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic        t_we  = 1'b0;
    logic [3:0]  t_wa  = 4'd0;
    logic [1:0]  t_be  = 2'b00;
    logic [15:0] t_din = 16'h0000;
    logic        t_re  = 1'b0;
    logic [3:0]  t_ra  = 4'd0;

    wire [15:0] o_dout  [NDUT];
    wire        o_valid [NDUT];
    wire        o_busy  [NDUT];

    always #5 clock = ~clock;

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            dual_port_ram_be_if #(.DATA_W(DW), .DEPTH(DP)) bus ();
            assign bus.wr_enb  = t_we;
            assign bus.wr_addr = t_wa;
            assign bus.wr_be   = t_be;
            assign bus.din     = t_din;
            assign bus.rd_enb  = t_re;
            assign bus.rd_addr = t_ra;
            assign o_dout[g]   = bus.dout;
            assign o_valid[g]  = bus.rd_valid;
            assign o_busy[g]   = bus.init_busy;
            dual_port_ram_be #(
                .DATA_W      (DW),
                .DEPTH       (DP),
                .READ_LATENCY((g < 2) ? 1 : 2),
                .RDW_MODE    (g % 2)
            ) dut (
                .clock(clock),
                .rst  (rst),
                .bus  (bus)
            );
        end
    endgenerate

    int checks   = 0;
    int failures = 0;

    // Reference model state (word level).
    logic [15:0] m_mem [DP];
    bit          m_busy;
    int          m_cnt;
    logic [15:0] e_dout  [NDUT];
    bit          e_valid [NDUT];
    bit          p_v;
    logic [15:0] p_old;
    logic [15:0] p_new;

    function automatic logic [15:0] mrg(input logic [15:0] old_w, input logic [15:0] new_w,
                                        input logic [1:0] be);
        logic [15:0] mask;
        mask = {{8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one clock edge to the model using the inputs present at the edge.
    task automatic model_edge();
        bit          acc;
        logic [15:0] old_w;
        logic [15:0] new_w;
        if (rst) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            p_v    = 1'b0;
            for (int g = 0; g < NDUT; g++) begin
                e_dout[g]  = 16'h0000;
                e_valid[g] = 1'b0;
            end
        end else begin
            acc   = !m_busy && t_re;
            old_w = m_mem[t_ra];
            new_w = (!m_busy && t_we && (t_wa == t_ra)) ? mrg(old_w, t_din, t_be) : old_w;
            for (int g = 0; g < NDUT; g++) begin
                if (g < 2) begin
                    e_valid[g] = acc;
                    if (acc) e_dout[g] = (g % 2 == 1) ? new_w : old_w;
                end else begin
                    e_valid[g] = p_v;
                    if (p_v) e_dout[g] = (g % 2 == 1) ? p_new : p_old;
                end
            end
            p_v   = acc;
            p_old = old_w;
            p_new = new_w;
            if (m_busy) begin
                m_mem[m_cnt] = 16'h0000;
                m_cnt++;
                if (m_cnt == DP) m_busy = 1'b0;
            end else if (t_we) begin
                m_mem[t_wa] = mrg(m_mem[t_wa], t_din, t_be);
            end
        end
    endtask

    // One clock: edge, model update, then compare every instance 1 time unit later.
    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        for (int g = 0; g < NDUT; g++) begin
            chk($sformatf("dut%0d_dout", g), 32'(o_dout[g]), 32'(e_dout[g]));
            chk($sformatf("dut%0d_rd_valid", g), 32'(o_valid[g]), 32'(e_valid[g]));
            chk($sformatf("dut%0d_init_busy", g), 32'(o_busy[g]), 32'(m_busy));
        end
    endtask

    task automatic drv(input logic we, input logic [3:0] wa, input logic [1:0] be,
                       input logic [15:0] d, input logic re, input logic [3:0] ra);
        t_we  = we;
        t_wa  = wa;
        t_be  = be;
        t_din = d;
        t_re  = re;
        t_ra  = ra;
    endtask

    // Release reset and count cycles until init_busy drops (bounded).
    task automatic count_init(input string nm);
        int n;
        rst = 1'b0;
        n   = 0;
        while (o_busy[0] && n < 40) begin
            cycle();
            n++;
        end
        chk(nm, 32'(n), 32'd16);
        drv(1'b0, 4'd0, 2'b00, 16'h0000, 1'b0, 4'd0);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [1:0]  be;
        logic [15:0] d;
        logic        re;
        logic [3:0]  ra;
        logic        ev;
        logic [15:0] ed_old;
        logic [15:0] ed_new;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [1:0] be,
                                input logic [15:0] d, input logic re, input logic [3:0] ra,
                                input logic ev, input logic [15:0] e0, input logic [15:0] e1);
        vec_t v;
        v.we = we; v.wa = wa; v.be = be; v.d = d; v.re = re; v.ra = ra;
        v.ev = ev; v.ed_old = e0; v.ed_new = e1;
        return v;
    endfunction

    initial begin
        logic [15:0] l2_exp [5];
        bit          l2_val [5];
        bit          seen;
        int          n;

        for (int i = 0; i < DP; i++) m_mem[i] = 16'h0000;

        // Directed vectors, expected dout/rd_valid for the latency-1 instances.
        for (int i = 0; i < DP; i++) vecs.push_back(mk(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'(i), 1'b1, 16'h0, 16'h0));
        vecs.push_back(mk(1'b1, 4'd3, 2'b11, 16'hA5A5, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1'b1, 4'd3, 2'b10, 16'h1200, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd3, 1'b1, 16'h12A5, 16'h12A5));
        vecs.push_back(mk(1'b1, 4'd5, 2'b11, 16'h1111, 1'b0, 4'd0, 1'b0, 16'h12A5, 16'h12A5));
        vecs.push_back(mk(1'b1, 4'd5, 2'b11, 16'h2222, 1'b1, 4'd5, 1'b1, 16'h1111, 16'h2222));
        vecs.push_back(mk(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd5, 1'b1, 16'h2222, 16'h2222));
        vecs.push_back(mk(1'b1, 4'd5, 2'b10, 16'hAB00, 1'b1, 4'd5, 1'b1, 16'h2222, 16'hAB22));
        vecs.push_back(mk(1'b1, 4'd6, 2'b11, 16'h5555, 1'b1, 4'd5, 1'b1, 16'hAB22, 16'hAB22));
        vecs.push_back(mk(1'b1, 4'd9, 2'b00, 16'hFFFF, 1'b0, 4'd0, 1'b0, 16'hAB22, 16'hAB22));
        vecs.push_back(mk(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd9, 1'b1, 16'h0000, 16'h0000));
        vecs.push_back(mk(1'b1, 4'd7, 2'b11, 16'h3C3C, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd7, 1'b1, 16'h3C3C, 16'h3C3C));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b0, 16'h3C3C, 16'h3C3C));

        // Reset for two cycles, then clear with write/read attempts pending.
        rst = 1'b1;
        cycle();
        cycle();
        drv(1'b1, 4'd0, 2'b11, 16'hFFFF, 1'b1, 4'd0);
        count_init("init_busy_cycles");

        foreach (vecs[i]) begin
            drv(vecs[i].we, vecs[i].wa, vecs[i].be, vecs[i].d, vecs[i].re, vecs[i].ra);
            cycle();
            chk($sformatf("vec%0d_valid_old", i), 32'(o_valid[0]), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_dout_old", i), 32'(o_dout[0]), 32'(vecs[i].ed_old));
            chk($sformatf("vec%0d_valid_new", i), 32'(o_valid[1]), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_dout_new", i), 32'(o_dout[1]), 32'(vecs[i].ed_new));
        end

        // Latency 2: back-to-back reads of 0,1,2.
        drv(1'b1, 4'd0, 2'b11, 16'h000A, 1'b0, 4'd0); cycle();
        drv(1'b1, 4'd1, 2'b11, 16'h000B, 1'b0, 4'd0); cycle();
        drv(1'b1, 4'd2, 2'b11, 16'h000C, 1'b0, 4'd0); cycle();
        l2_val[0] = 1'b0; l2_exp[0] = 16'h0000;
        l2_val[1] = 1'b1; l2_exp[1] = 16'h000A;
        l2_val[2] = 1'b1; l2_exp[2] = 16'h000B;
        l2_val[3] = 1'b1; l2_exp[3] = 16'h000C;
        l2_val[4] = 1'b0; l2_exp[4] = 16'h000C;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drv(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'(k));
            else       drv(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0);
            cycle();
            chk($sformatf("lat2_valid_c%0d", k + 1), 32'(o_valid[2]), 32'(l2_val[k]));
            if (k > 0) chk($sformatf("lat2_dout_c%0d", k + 1), 32'(o_dout[2]), 32'(l2_exp[k]));
        end

        // Reset when clr_ptr has reached 7: clear must restart from scratch.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (7) cycle();
        rst = 1'b1;
        cycle();
        chk("midclear_busy", 32'(o_busy[0]), 32'd1);
        count_init("midclear_init_cycles");

        // Reset with a latency-2 read in flight.
        drv(1'b1, 4'd4, 2'b11, 16'h7777, 1'b0, 4'd0); cycle();
        drv(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd4); cycle();
        drv(1'b0, 4'd0, 2'b00, 16'h0000, 1'b0, 4'd0);
        rst = 1'b1;
        cycle();
        chk("inflight_valid_old", 32'(o_valid[2]), 32'd0);
        chk("inflight_dout_old", 32'(o_dout[2]), 32'd0);
        chk("inflight_valid_new", 32'(o_valid[3]), 32'd0);
        chk("inflight_dout_new", 32'(o_dout[3]), 32'd0);
        rst  = 1'b0;
        seen = 1'b0;
        n    = 0;
        while (o_busy[0] && n < 40) begin
            cycle();
            n++;
            if (o_valid[2] || o_valid[3]) seen = 1'b1;
        end
        chk("inflight_never_valid", 32'(seen), 32'd0);
        chk("inflight_init_cycles", 32'(n), 32'd16);

        // Randomised traffic, occasional reset, collisions favoured.
        for (int i = 0; i < 700; i++) begin
            rst   = ($urandom_range(0, 249) == 0);
            t_we  = 1'($urandom_range(0, 1));
            t_be  = 2'($urandom_range(0, 3));
            t_din = 16'($urandom);
            t_re  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 0) begin
                t_wa = 4'($urandom_range(0, 3));
                t_ra = 4'($urandom_range(0, 3));
            end else begin
                t_wa = 4'($urandom_range(0, 15));
                t_ra = 4'($urandom_range(0, 15));
            end
            cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
